// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory / MMIO block: register addresses,
// STATUS bit positions and the address decoder used by the top level.
package dmem_pkg;

    localparam logic [31:0] ADDR_LED    = 32'h0000_1000;
    localparam logic [31:0] ADDR_CYCLES = 32'h0000_1004;
    localparam logic [31:0] ADDR_TXDATA = 32'h0000_1008;
    localparam logic [31:0] ADDR_STATUS = 32'h0000_100C;

    localparam int STATUS_FULL_BIT  = 8;
    localparam int STATUS_EMPTY_BIT = 9;
    localparam int STATUS_OVF_BIT   = 10;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_LED,
        SEL_CYCLES,
        SEL_TXDATA,
        SEL_STATUS
    } sel_e;

    // RAM occupies every word address whose bits above the RAM index are zero.
    function automatic sel_e decodeAddr(input logic [29:0] wordAddr,
                                        input int unsigned ramAddrBits);
        sel_e sel;
        sel = SEL_NONE;
        if ((wordAddr >> ramAddrBits) == 30'd0)   sel = SEL_RAM;
        else if (wordAddr == ADDR_LED[31:2])      sel = SEL_LED;
        else if (wordAddr == ADDR_CYCLES[31:2])   sel = SEL_CYCLES;
        else if (wordAddr == ADDR_TXDATA[31:2])   sel = SEL_TXDATA;
        else if (wordAddr == ADDR_STATUS[31:2])   sel = SEL_STATUS;
        return sel;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Byte-wide transmit FIFO with occupancy count; push and pop in the same
// cycle are both honoured, even when full.
module tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pushOk;
    logic          popOk;

    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign count  = count_q;
    assign dout   = mem_q[rdPtr_q];
    assign pushOk = push & (~full | pop);
    assign popOk  = pop & ~empty;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (pushOk) begin
            wrPtr_d = (wrPtr_q == PW'(DEPTH - 1)) ? '0 : wrPtr_q + 1'b1;
        end
        if (popOk) begin
            rdPtr_d = (rdPtr_q == PW'(DEPTH - 1)) ? '0 : rdPtr_q + 1'b1;
        end
        case ({pushOk, popOk})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; contents are only visible once counted valid.
    always_ff @(posedge clk) begin
        if (!rst && pushOk) begin
            mem_q[wrPtr_q] <= din;
        end
    end

endmodule

// File: rtl/dmem_mmio.sv
// CPU data memory with memory-mapped LED, cycle counter, transmit FIFO and
// status registers; loads are combinational, stores land on the clock edge.
module dmem_mmio
    import dmem_pkg::*;
#(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [9:0]  leds,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   ram_q [RAM_WORDS];
    logic [9:0]    leds_q, leds_d;
    logic [31:0]   cycles_q, cycles_d;
    logic          overflow_q, overflow_d;

    logic [29:0]   wordAddr;
    logic [1:0]    unusedAddrBits;
    logic [AW-1:0] ramIdx;
    sel_e          sel;
    logic          pushReq;
    logic          pop;
    logic          fifoFull;
    logic          fifoEmpty;
    logic [CW-1:0] fifoCount;
    logic          ovfEvent;
    logic [31:0]   statusWord;

    assign wordAddr       = ALUResult[31:2];
    assign unusedAddrBits = ALUResult[1:0];
    assign ramIdx         = ALUResult[AW+1:2];
    assign sel            = decodeAddr(wordAddr, AW);

    assign pushReq  = MemWrite && (sel == SEL_TXDATA);
    assign pop      = ~fifoEmpty & tx_ready;
    assign ovfEvent = pushReq & fifoFull & ~pop;

    tx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_tx_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (pushReq),
        .pop  (pop),
        .din  (WriteData[7:0]),
        .dout (tx_data),
        .count(fifoCount),
        .full (fifoFull),
        .empty(fifoEmpty)
    );

    assign tx_valid = ~fifoEmpty;
    assign leds     = leds_q;

    // A same-cycle overflow outranks a STATUS clear, and a CYCLES clear
    // outranks the increment.
    always_comb begin
        leds_d     = leds_q;
        cycles_d   = cycles_q + 32'd1;
        overflow_d = overflow_q;
        if (MemWrite && (sel == SEL_LED)) begin
            leds_d = WriteData[9:0];
        end
        if (MemWrite && (sel == SEL_CYCLES)) begin
            cycles_d = '0;
        end
        if (ovfEvent) begin
            overflow_d = 1'b1;
        end else if (MemWrite && (sel == SEL_STATUS)) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            leds_q     <= '0;
            cycles_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            leds_q     <= leds_d;
            cycles_q   <= cycles_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && MemWrite && (sel == SEL_RAM)) begin
            ram_q[ramIdx] <= WriteData;
        end
    end

    always_comb begin
        statusWord                   = '0;
        statusWord[CW-1:0]           = fifoCount;
        statusWord[STATUS_FULL_BIT]  = fifoFull;
        statusWord[STATUS_EMPTY_BIT] = fifoEmpty;
        statusWord[STATUS_OVF_BIT]   = overflow_q;
    end

    always_comb begin
        ReadData = '0;
        case (sel)
            SEL_RAM:    ReadData = ram_q[ramIdx];
            SEL_LED:    ReadData = {22'b0, leds_q};
            SEL_CYCLES: ReadData = cycles_q;
            SEL_STATUS: ReadData = statusWord;
            default:    ReadData = '0;
        endcase
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed testbench for dmem_mmio: RAM, LED, cycle counter, transmit FIFO,
// STATUS register and reset behaviour against hand-computed values.
module tb_dmem_mmio;

    logic        clk;
    logic        rst;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [9:0]  leds;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int checkCount = 0;
    int errorCount = 0;

    dmem_mmio #(
        .RAM_WORDS (64),
        .FIFO_DEPTH(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .MemWrite (MemWrite),
        .ALUResult(ALUResult),
        .WriteData(WriteData),
        .ReadData (ReadData),
        .leds     (leds),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [31:0] addr,
                                 input logic [31:0] data, input logic ready);
        MemWrite  = we;
        ALUResult = addr;
        WriteData = data;
        tx_ready  = ready;
        #1;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 32'h1004, 32'h0, 1'b0);
        stepClock();
        stepClock();
        checkOutput("reset_cycles", ReadData, 32'h0);
        checkOutput("reset_leds", {22'b0, leds}, 32'h0);
        checkOutput("reset_txvalid", {31'b0, tx_valid}, 32'h0);
        rst = 1'b0;
        applyStimulus(1'b0, 32'h100C, 32'h0, 1'b0);
        checkOutput("reset_status", ReadData, 32'h200);

        // Counter counts edges since reset release
        repeat (5) stepClock();
        applyStimulus(1'b0, 32'h1004, 32'h0, 1'b0);
        checkOutput("cycles_at_5", ReadData, 32'd5);
        applyStimulus(1'b1, 32'h1004, 32'h0, 1'b0);
        checkOutput("cycles_preclear", ReadData, 32'd5);
        stepClock();
        applyStimulus(1'b0, 32'h1004, 32'h0, 1'b0);
        checkOutput("cycles_cleared", ReadData, 32'd0);
        stepClock();
        checkOutput("cycles_after_clear", ReadData, 32'd1);

        // RAM store/load, same-cycle old value, low-bit ignore, bounds
        applyStimulus(1'b1, 32'h10, 32'h1234_5678, 1'b0);
        stepClock();
        applyStimulus(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
        checkOutput("ram_same_cycle_old", ReadData, 32'h1234_5678);
        stepClock();
        applyStimulus(1'b0, 32'h10, 32'h0, 1'b0);
        checkOutput("ram_readback", ReadData, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 32'h13, 32'h0, 1'b0);
        checkOutput("ram_lowbits_ignored", ReadData, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 32'hFC, 32'hCAFE_F00D, 1'b0);
        stepClock();
        applyStimulus(1'b0, 32'hFC, 32'h0, 1'b0);
        checkOutput("ram_last_word", ReadData, 32'hCAFE_F00D);
        applyStimulus(1'b0, 32'h100, 32'h0, 1'b0);
        checkOutput("ram_past_end", ReadData, 32'h0);
        applyStimulus(1'b1, 32'h110, 32'h5555_5555, 1'b0);
        stepClock();
        applyStimulus(1'b0, 32'h10, 32'h0, 1'b0);
        checkOutput("ram_no_alias", ReadData, 32'hDEAD_BEEF);

        // LED register and unmapped / write-only reads
        applyStimulus(1'b1, 32'h1000, 32'hFFFF_FFFF, 1'b0);
        stepClock();
        checkOutput("leds_value", {22'b0, leds}, 32'h3FF);
        applyStimulus(1'b1, 32'h2000, 32'h0, 1'b0);
        stepClock();
        checkOutput("leds_unmapped_write", {22'b0, leds}, 32'h3FF);
        applyStimulus(1'b0, 32'h1000, 32'h0, 1'b0);
        checkOutput("leds_read", ReadData, 32'h3FF);
        applyStimulus(1'b0, 32'h2000, 32'h0, 1'b0);
        checkOutput("unmapped_read", ReadData, 32'h0);
        applyStimulus(1'b0, 32'h1008, 32'h0, 1'b0);
        checkOutput("txdata_read", ReadData, 32'h0);

        // Fill FIFO past capacity with the sink stalled
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 32'h1008, 32'h41 + i, 1'b0);
            stepClock();
            if (i == 0) begin
                checkOutput("fifo_first_valid", {31'b0, tx_valid}, 32'h1);
                checkOutput("fifo_first_data", {24'b0, tx_data}, 32'h41);
            end
        end
        applyStimulus(1'b0, 32'h100C, 32'h0, 1'b0);
        checkOutput("status_full_ovf", ReadData, 32'h504);
        checkOutput("fifo_head_41", {24'b0, tx_data}, 32'h41);

        // Push while full with a pop in the same cycle
        applyStimulus(1'b1, 32'h1008, 32'h99, 1'b1);
        stepClock();
        applyStimulus(1'b0, 32'h100C, 32'h0, 1'b0);
        checkOutput("status_push_pop_full", ReadData, 32'h504);
        checkOutput("fifo_head_42", {24'b0, tx_data}, 32'h42);

        applyStimulus(1'b1, 32'h100C, 32'h0, 1'b0);
        stepClock();
        applyStimulus(1'b0, 32'h100C, 32'h0, 1'b0);
        checkOutput("status_ovf_cleared", ReadData, 32'h104);

        // Drain two entries, then reset mid-drain
        applyStimulus(1'b0, 32'h100C, 32'h0, 1'b1);
        checkOutput("drain_42", {24'b0, tx_data}, 32'h42);
        stepClock();
        applyStimulus(1'b0, 32'h100C, 32'h0, 1'b1);
        checkOutput("drain_43", {24'b0, tx_data}, 32'h43);
        stepClock();
        applyStimulus(1'b0, 32'h100C, 32'h0, 1'b0);
        checkOutput("status_count2", ReadData, 32'h002);
        checkOutput("drain_head_44", {24'b0, tx_data}, 32'h44);

        rst = 1'b1;
        applyStimulus(1'b1, 32'h10, 32'h0, 1'b1);
        stepClock();
        rst = 1'b0;
        applyStimulus(1'b0, 32'h10, 32'h0, 1'b0);
        checkOutput("rst_txvalid", {31'b0, tx_valid}, 32'h0);
        checkOutput("rst_ram_kept", ReadData, 32'hDEAD_BEEF);
        checkOutput("rst_leds", {22'b0, leds}, 32'h0);
        applyStimulus(1'b0, 32'h100C, 32'h0, 1'b0);
        checkOutput("rst_status", ReadData, 32'h200);

        // Push into empty FIFO with sink ready: visible only next cycle
        applyStimulus(1'b1, 32'h1008, 32'h60, 1'b1);
        checkOutput("empty_push_same_cycle", {31'b0, tx_valid}, 32'h0);
        stepClock();
        applyStimulus(1'b0, 32'h100C, 32'h0, 1'b0);
        checkOutput("empty_push_valid", {31'b0, tx_valid}, 32'h1);
        checkOutput("empty_push_data", {24'b0, tx_data}, 32'h60);
        checkOutput("empty_push_status", ReadData, 32'h001);
        applyStimulus(1'b0, 32'h100C, 32'h0, 1'b1);
        stepClock();
        applyStimulus(1'b0, 32'h100C, 32'h0, 1'b0);
        checkOutput("final_status", ReadData, 32'h200);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
